// File: rtl/fme_pkg.sv
// Shared fractional-motion-estimation definitions: stage data widths and the
// cost-select FSM encoding used by the transform and input stages.
package fme_pkg;

  localparam int SATD_W    = 16;
  localparam int MV_COST_W = 8;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CMP   = 2'd2,
    ST_DONE  = 2'd3
  } fme_state_t;

endpackage

// File: rtl/satd_cost_select_sat_accum.sv
// Saturating COST_W-bit accumulator with synchronous clear; the clear wins
// over a same-cycle add so a new candidate always starts from zero.
module sat_accum
  import fme_pkg::*;
#(
  parameter int COST_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [SATD_W-1:0] din,
  output logic [COST_W-1:0] acc
);

  logic [COST_W:0]   sum_wide;
  logic [COST_W-1:0] sum_sat;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to remember the old value.
  always_comb begin
    sum_wide = {1'b0, acc} + (COST_W + 1)'(din);
    sum_sat  = sum_wide[COST_W] ? '1 : sum_wide[COST_W-1:0];
  end

  // NOTE: state updates use non-blocking assignments so all flops sample
  // their inputs from the same clock edge regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_sat;
    end
  end

endmodule

// File: rtl/satd_cost_select.sv
// Accumulates SUBBLK 4x4 SATD values plus an MV rate cost per fractional-pel
// candidate and reports the index and cost of the cheapest one.
module satd_cost_select
  import fme_pkg::*;
#(
  parameter int NUM_CAND = 9,
  parameter int SUBBLK   = 4,
  parameter int COST_W   = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 satd_valid,
  input  logic [SATD_W-1:0]    satd_in,
  input  logic [MV_COST_W-1:0] mv_cost,
  output logic                 satd_ready,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     best_idx,
  output logic [COST_W-1:0]    best_cost
);

  localparam int                SUB_W     = (SUBBLK > 1) ? $clog2(SUBBLK) : 1;
  localparam logic [SUB_W-1:0]  LAST_SUB  = SUB_W'(SUBBLK - 1);
  localparam logic [IDX_W-1:0]  LAST_CAND = IDX_W'(NUM_CAND - 1);

  fme_state_t             state;
  logic [SUB_W-1:0]       sub_cnt;
  logic [IDX_W-1:0]       cand_cnt;
  logic [MV_COST_W-1:0]   mv_hold;
  logic [COST_W-1:0]      acc;
  logic [COST_W:0]        total_wide;
  logic [COST_W-1:0]      total;
  logic                   xfer;
  logic                   acc_clr;

  assign xfer    = satd_valid && satd_ready;
  assign acc_clr = ((state == ST_IDLE) && start) ||
                   ((state == ST_CMP) && (cand_cnt != LAST_CAND));

  sat_accum #(.COST_W(COST_W)) u_accum (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (xfer),
    .din (satd_in),
    .acc (acc)
  );

  // Adding the MV cost can also overflow when the SATD sum is near the cap.
  always_comb begin
    total_wide = {1'b0, acc} + (COST_W + 1)'(mv_hold);
    total      = total_wide[COST_W] ? '1 : total_wide[COST_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      sub_cnt    <= '0;
      cand_cnt   <= '0;
      mv_hold    <= '0;
      satd_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      best_idx   <= '0;
      best_cost  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_ACCUM;
            sub_cnt    <= '0;
            cand_cnt   <= '0;
            satd_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (xfer) begin
            if (sub_cnt == '0) mv_hold <= mv_cost;
            sub_cnt <= sub_cnt + SUB_W'(1);
            if (sub_cnt == LAST_SUB) begin
              state      <= ST_CMP;
              satd_ready <= 1'b0;
            end
          end
        end
        ST_CMP: begin
          // Strict less-than keeps the lower index on ties.
          if ((cand_cnt == '0) || (total < best_cost)) begin
            best_cost <= total;
            best_idx  <= cand_cnt;
          end
          if (cand_cnt == LAST_CAND) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            cand_cnt   <= cand_cnt + IDX_W'(1);
            sub_cnt    <= '0;
            state      <= ST_ACCUM;
            satd_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          satd_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_satd_cost_select.sv
// Randomized and directed bench for satd_cost_select; a default instance and a
// COST_W=16 instance share stimulus and are compared against a sum/min model.
module tb_satd_cost_select;
  import fme_pkg::*;

  localparam int NUM_CAND = 9;
  localparam int SUBBLK   = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 satd_valid = 1'b0;
  logic [SATD_W-1:0]    satd_in = '0;
  logic [MV_COST_W-1:0] mv_cost = '0;

  logic              satd_ready, busy, done;
  logic [IDX_W-1:0]  best_idx;
  logic [19:0]       best_cost;
  logic              satd_ready16, busy16, done16;
  logic [IDX_W-1:0]  best_idx16;
  logic [15:0]       best_cost16;

  int n_total = 0;
  int n_bad   = 0;

  int satd_tab[NUM_CAND][SUBBLK];
  int mv_tab[NUM_CAND];

  always #5 clk = ~clk;

  satd_cost_select dut (
    .clk(clk), .rst(rst), .start(start), .satd_valid(satd_valid),
    .satd_in(satd_in), .mv_cost(mv_cost), .satd_ready(satd_ready),
    .busy(busy), .done(done), .best_idx(best_idx), .best_cost(best_cost)
  );

  satd_cost_select #(.COST_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .satd_valid(satd_valid),
    .satd_in(satd_in), .mv_cost(mv_cost), .satd_ready(satd_ready16),
    .busy(busy16), .done(done16), .best_idx(best_idx16), .best_cost(best_cost16)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Cost of a candidate = min(sum of SATDs, cap) + mv, capped; first minimum wins.
  function automatic void model(input int cw, output int idx, output longint cost);
    longint cap = (longint'(1) << cw) - 1;
    idx  = 0;
    cost = 0;
    for (int c = 0; c < NUM_CAND; c++) begin
      longint t = 0;
      for (int s = 0; s < SUBBLK; s++) t += satd_tab[c][s];
      if (t > cap) t = cap;
      t += mv_tab[c];
      if (t > cap) t = cap;
      if (c == 0 || t < cost) begin
        cost = t;
        idx  = c;
      end
    end
  endfunction

  // gap_mode: 0 valid always high, 1 toggling, 2 random gaps.
  // abort_cand >= 0 asserts reset in the middle of that candidate instead.
  task automatic run_search(input string tag, input int gap_mode, input bit restart_mid,
                            input bit check_lat, input int abort_cand);
    int c = 0, s = 0, cycles = 0, dones = 0, ready_bad = 0, lat = -1;
    bit xfer = 1'b0, seen_done = 1'b0, aborted = 1'b0;
    int exp_idx, exp_idx16;
    longint exp_cost, exp_cost16;
    model(20, exp_idx, exp_cost);
    model(16, exp_idx16, exp_cost16);

    start = 1'b1;
    satd_valid = 1'b0;
    while (!seen_done && cycles < 2000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      start = restart_mid && (cycles == 20 || cycles == 41);
      if (done) begin
        dones++;
        seen_done = 1'b1;
        lat = cycles;
      end
      if (xfer) begin
        s++;
        if (s == SUBBLK) begin
          s = 0;
          c++;
          if (satd_ready) ready_bad++;
        end
      end
      if (abort_cand >= 0 && c == abort_cand && s == 2) begin
        #2 rst = 1'b0;
        #1;
        check({tag, " rst satd_ready"}, satd_ready, 0);
        check({tag, " rst busy"}, busy, 0);
        check({tag, " rst done"}, done, 0);
        check({tag, " rst best_idx"}, best_idx, 0);
        check({tag, " rst best_cost"}, best_cost, 0);
        aborted = 1'b1;
        break;
      end
      if (c < NUM_CAND) begin
        case (gap_mode)
          0:       satd_valid = 1'b1;
          1:       satd_valid = (cycles % 2 == 0);
          default: satd_valid = ($urandom_range(0, 3) != 0);
        endcase
        satd_in = SATD_W'(satd_tab[c][s]);
        mv_cost = (s == 0) ? MV_COST_W'(mv_tab[c]) : MV_COST_W'($urandom);
      end else begin
        satd_valid = 1'b0;
      end
      xfer = satd_valid && satd_ready;
    end
    start = 1'b0;
    satd_valid = 1'b0;

    if (aborted) begin
      @(negedge clk);
      rst = 1'b1;
      repeat (60) begin
        @(negedge clk);
        if (done) dones++;
      end
      check({tag, " done after reset"}, dones, 0);
      check({tag, " busy after reset"}, busy, 0);
      return;
    end

    check({tag, " timeout"}, seen_done, 1);
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    check({tag, " done pulses"}, dones, 1);
    check({tag, " ready in cmp"}, ready_bad, 0);
    check({tag, " idx"}, best_idx, exp_idx);
    check({tag, " cost"}, best_cost, exp_cost);
    check({tag, " idx16"}, best_idx16, exp_idx16);
    check({tag, " cost16"}, best_cost16, exp_cost16);
    check({tag, " idle busy"}, busy, 0);
    if (check_lat) check({tag, " latency"}, lat, NUM_CAND * (SUBBLK + 1) + 1);
  endtask

  task automatic fill_const(input int v);
    for (int c = 0; c < NUM_CAND; c++) begin
      mv_tab[c] = 0;
      for (int s = 0; s < SUBBLK; s++) satd_tab[c][s] = v;
    end
  endtask

  task automatic fill_random(input int max_satd);
    for (int c = 0; c < NUM_CAND; c++) begin
      mv_tab[c] = $urandom_range(0, 255);
      for (int s = 0; s < SUBBLK; s++) satd_tab[c][s] = $urandom_range(0, max_satd);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset satd_ready", satd_ready, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset best_idx", best_idx, 0);
    check("reset best_cost", best_cost, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle busy", busy, 0);

    fill_const(100);
    for (int c = 0; c < NUM_CAND; c++) mv_tab[c] = c;
    run_search("uniform", 0, 1'b0, 1'b1, -1);
    check("uniform spec idx", best_idx, 0);
    check("uniform spec cost", best_cost, 400);

    fill_const(200);
    for (int s = 0; s < SUBBLK; s++) satd_tab[5][s] = 10;
    run_search("cand5", 0, 1'b0, 1'b0, -1);
    check("cand5 spec idx", best_idx, 5);
    check("cand5 spec cost", best_cost, 40);

    fill_const(125);
    satd_tab[2] = '{12, 12, 12, 14};
    satd_tab[7] = '{10, 10, 10, 20};
    run_search("tie", 0, 1'b0, 1'b0, -1);
    check("tie spec idx", best_idx, 2);
    check("tie spec cost", best_cost, 50);

    fill_const(100);
    for (int c = 0; c < NUM_CAND; c++) mv_tab[c] = c;
    run_search("toggle", 1, 1'b1, 1'b0, -1);

    fill_random(4000);
    run_search("abort", 0, 1'b0, 1'b0, 4);
    fill_const(100);
    for (int c = 0; c < NUM_CAND; c++) mv_tab[c] = c;
    run_search("post_reset", 0, 1'b0, 1'b1, -1);

    fill_const(65535);
    run_search("saturate", 0, 1'b0, 1'b0, -1);
    check("saturate spec cost16", best_cost16, 65535);

    for (int r = 0; r < 6; r++) begin
      fill_random((r % 2 == 0) ? 20 : 65535);
      run_search($sformatf("rand%0d", r), 2, r[0], 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/satd_cost_select.md
SATD_COST_SELECT -- requirements
Module: satd_cost_select

Interface
REQ-001 Parameter NUM_CAND, default 9, number of fractional-pel candidates per prediction unit (centre plus 8 half/quarter neighbours).
REQ-002 Parameter SUBBLK, default 4, number of 4x4 SATD results per candidate (8x8 PU).
REQ-003 Parameter COST_W, default 20, width of the accumulated cost.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins a new PU search.
REQ-007 satd_valid  input  1  satd_in holds one 4x4 Hadamard SATD value this cycle.
REQ-008 satd_in  input  16  unsigned 4x4 SATD from the transform stage.
REQ-009 mv_cost  input  8  unsigned motion-vector rate cost of the current candidate.
REQ-010 satd_ready  output  1  block accepts satd_in this cycle.
REQ-011 busy  output  1  search in progress.
REQ-012 done  output  1  one-cycle pulse; best_idx/best_cost are final.
REQ-013 best_idx  output  4  index (0..NUM_CAND-1) of minimum-cost candidate.
REQ-014 best_cost  output  COST_W  cost of best_idx.

Function
REQ-015 FSM states IDLE, ACCUM, CMP, DONE shall be the only states.
REQ-016 IDLE: start=1 -> ACCUM; clear accumulator, sub-block counter, candidate counter; start otherwise ignored.
REQ-017 satd_ready shall be 1 only in ACCUM; a transfer occurs when satd_valid and satd_ready are both 1.
REQ-018 On each transfer: accumulator += satd_in (zero-extended), saturating at 2^COST_W-1; sub-block counter increments.
REQ-019 mv_cost shall be sampled on the first transfer of each candidate (sub-block counter 0) and held.
REQ-020 On the SUBBLK-th transfer: ACCUM -> CMP next cycle; satd_ready deasserts in CMP.
REQ-021 CMP (one cycle): total = saturating accumulator + held mv_cost; if candidate counter = 0 or total < best_cost (strict), load best_cost = total and best_idx = candidate counter.
REQ-022 Ties shall keep the earlier (lower) index.
REQ-023 CMP: if candidate counter = NUM_CAND-1 -> DONE, else increment candidate counter, clear accumulator and sub-block counter, -> ACCUM.
REQ-024 DONE: done=1 for exactly one cycle, -> IDLE; best_idx/best_cost shall hold their values until the next start is accepted.
REQ-025 busy shall be 1 in ACCUM, CMP, DONE; 0 in IDLE.
REQ-026 start while busy shall be ignored; the current search continues undisturbed.
REQ-027 satd_valid while satd_ready=0 shall be ignored (no accumulation, no counter change).
REQ-028 Minimum latency from start to done: NUM_CAND*(SUBBLK+1)+1 cycles with satd_valid held high.

Reset
REQ-029 rst=0 shall asynchronously force IDLE and clear every counter, accumulator and held mv_cost.
REQ-030 Output reset values: satd_ready=0, busy=0, done=0, best_idx=0, best_cost=0.
REQ-031 Reset mid-search shall discard partial results; no done pulse follows until a new start.

Structure
REQ-032 FSM state encoding, SATD width (16) and mv_cost width (8) shall live in the shared FME package used by the transform and input stages.
REQ-033 One sub-module sat_accum (saturating COST_W adder with clear) is natural; all else inline.

Verification
REQ-034 Defaults, satd_in=100 for all 36 transfers, mv_cost = candidate index -> done after 46 cycles, best_idx=0, best_cost=400.
REQ-035 Candidate 5 sub-blocks=10 each, others 200 each, mv_cost=0 -> best_idx=5, best_cost=40.
REQ-036 Candidates 2 and 7 both total 50, others 500 -> best_idx=2 (tie keeps lower index).
REQ-037 satd_valid toggled 1/0 every cycle, start pulsed again mid-search -> same result as REQ-034, one done pulse, satd_ready=0 in every CMP cycle.
REQ-038 rst asserted during candidate 4 -> outputs at reset values immediately; new start then full search yields correct result.
REQ-039 COST_W=16, satd_in=65535 x4 -> accumulator and best_cost saturate at 65535, no wrap.
